anim_sequencer: RTL and testbench
=================================

Name: anim_sequencer

Overview:
- Frame sequencer for the 7-segment animation engine.
- Registers the selected animation index and drives it to the frame-limit lookup stage. That stage combinationally returns the inclusive last-frame index (`limit`).
- Steps a frame counter `frame` through 0..`limit` at a programmable rate. `frame` feeds the segment-pattern ROM downstream.
- Supports loop, one-shot and ping-pong playback, plus pause and single-step.

Parameters:
- `BASE_DIV`, 1000000, clock cycles per frame at `speed`=0.
- `PRESC_W`, 24, prescaler counter width; must hold `BASE_DIV`-1.

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `ena`  in  1  global enable; when 0 all state holds and pulses are 0
- `animation`  in  6  requested animation index
- `limit`  in  6  last frame index for `ani_q`, from the limit lookup (combinational)
- `speed`  in  3  rate select
- `mode`  in  2  00 loop, 01 one-shot, 10 ping-pong, 11 = loop
- `run`  in  1  1 run, 0 pause
- `step`  in  1  level; each rising edge advances one frame while paused
- `ani_q`  out  6  registered animation index, drives the limit lookup
- `frame`  out  6  current frame index
- `frame_tick`  out  1  one-cycle pulse, aligned with each new `frame` value
- `wrap`  out  1  one-cycle pulse when a frame sequence completes or reverses
- `done`  out  1  high while one-shot is finished
- `ani_changed`  out  1  one-cycle pulse, aligned with an `ani_q` update

Behaviour:
- **Reset** (`rst_n`=0 at a `clk` edge):
  - `ani_q`=0, `frame`=0, prescaler=0, `dir`=up, `step_d`=0.
  - All pulses 0, `done`=0, state=HOLD.
  - Reset mid-sequence discards everything.
- **States.** RUN, HOLD, DONE.
  - RUN->HOLD when `run`=0; HOLD->RUN when `run`=1.
  - RUN->DONE on a one-shot terminal advance.
  - DONE->RUN or HOLD (following `run`) on `ani_changed` or a `mode` change.
  - DONE ignores `run`, `step` and ticks; `done`=1 exactly in DONE.
- **Animation change.** `animation` != `ani_q` at an edge (with `ena`=1) produces, on that edge:
  - `ani_q`<=`animation`, `frame`<=0, prescaler<=0, `dir`<=up, `ani_changed`<=1.
  - No advance that cycle; this has priority over tick and step.
  - Latency is 1 cycle. `limit` is valid from the cycle after.
- **Prescaler.**
  - `period` = `BASE_DIV` >> `speed`, forced to 1 if it evaluates to 0.
  - Counts only in RUN.
  - Terminal when cnt >= `period`-1, so a mid-count speed increase fires at once. On terminal, cnt<=0 and an advance occurs.
  - In HOLD/DONE the count is frozen.
- **Step.** A rising edge of `step` (`step_d` register) in HOLD gives exactly one advance. Ignored in RUN and DONE.
- **Advance**, registered; `frame_tick`=1 in the cycle `frame` shows its new value:
  - Loop: `frame` < `limit` -> +1; else `frame`<=0 with `wrap`=1.
  - One-shot:
    - `frame` < `limit` -> +1.
    - `frame` >= `limit` -> hold `frame`, `wrap`=1, go to DONE. `frame_tick`=0 on this terminal advance.
  - Ping-pong up:
    - `frame` < `limit` -> +1.
    - Else `dir`<=down, `frame`<=`limit`-1 (0 if `limit`=0), `wrap`=1.
  - Ping-pong down:
    - `frame` > 0 -> -1.
    - At 0 -> `dir`<=up, `frame`<=1 (0 if `limit`=0), `wrap`=1.
- **Out-of-range frame.** If `frame` > `limit` (`limit` changed externally), the next advance sets `frame`<=0 with `wrap`=1 in every mode. In one-shot this goes to DONE instead.
- **`limit`=0.** `frame` stays 0 and every advance pulses `wrap`.
- **`limit`=63** (lookup default) is legal: `frame` uses the full 0..63 range.
- **Width rules.** 6-bit compares are unsigned. Prescaler is `PRESC_W` bits; `period`-1 is computed in `PRESC_W` bits.
- **Gating.** `ena`=0 freezes all registers except reset, and forces pulses to 0.

Decomposition:
- Package `anim_pkg`:
  - state enum (ST_RUN, ST_HOLD, ST_DONE);
  - mode constants (MODE_LOOP, MODE_ONESHOT, MODE_PINGPONG);
  - `FRAME_W`=6, `ANI_W`=6.
- Sub-module `anim_prescaler`: rate divider with `clk`, `rst_n`, `en`, `clr`, `speed` in and `tick` out.
- FSM and frame logic stay in the top module.

Test Plan (`BASE_DIV`=8, `ena`=1; the testbench models the limit lookup):
- **Reset and first change.** Reset, then `animation`=0, `run`=1, `mode`=00 (`limit`=9), `speed`=0.
  - `frame_tick` every 8 cycles.
  - `frame` sequence 0,1..9,0.
  - `wrap` pulses exactly with the 9->0 step.
- **Animation change mid-sequence.** `animation` 0->1 while `frame`=5.
  - Next cycle: `ani_q`=1, `frame`=0, `ani_changed`=1, prescaler restarts.
  - With `limit`=11, the sequence runs to 11 before wrapping.
- **One-shot.** `mode`=01, `animation`=7 (`limit`=1).
  - `frame` 0->1.
  - Next tick: `wrap`=1, `done`=1, `frame` holds 1.
  - `step` pulses have no effect.
  - Changing `animation` clears `done` and `frame`=0.
- **Ping-pong.** `mode`=10, `animation`=8 (`limit`=3).
  - `frame` sequence 0,1,2,3,2,1,0,1.
  - `wrap` at 3->2 and 0->1.
- **Pause and step.** `run`=0 at `frame`=4.
  - No ticks over 100 cycles.
  - Three `step` rising edges (level held several cycles each) give `frame` 5,6,7, each with one `frame_tick`.
  - `run`=1 resumes with the prescaler count preserved.
- **Speed, `ena` and reset.**
  - `speed`=7 gives a period of 1: a tick every cycle.
  - `speed` 0->2 with cnt=5 ticks on the next edge.
  - `ena`=0 for 20 cycles: outputs frozen, pulses 0.
  - `rst_n`=0 for one edge mid-run: all outputs return to reset values.

Source files
------------

// File: rtl/anim_pkg.sv
// Shared types and constants for the 7-segment animation frame sequencer.
package anim_pkg;
  localparam int FRAME_W = 6;
  localparam int ANI_W   = 6;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
endpackage

// File: rtl/anim_prescaler.sv
// Frame-rate divider: fires tick once every (BASE_DIV >> speed) enabled cycles.
module anim_prescaler #(
  parameter int BASE_DIV = 1000000,
  parameter int PRESC_W  = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic [2:0] speed,
  output logic       tick
);
  logic [PRESC_W-1:0] cnt;
  logic [PRESC_W-1:0] period;
  logic [PRESC_W-1:0] last;

  always_comb begin
    period = PRESC_W'(BASE_DIV) >> speed;
    if (period == '0) period = PRESC_W'(1);
    last = period - PRESC_W'(1);
  end

  // >= rather than == so a speed-up mid-count fires immediately
  assign tick = en && !clr && (cnt >= last);

  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= tick ? '0 : cnt + PRESC_W'(1);
  end
endmodule

// File: rtl/anim_sequencer.sv
// Frame sequencer: registers the animation index and steps frame 0..limit
// in loop, one-shot or ping-pong order, with pause and single-step.
module anim_sequencer
  import anim_pkg::*;
#(
  parameter int BASE_DIV = 1000000,
  parameter int PRESC_W  = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [ANI_W-1:0]   animation,
  input  logic [FRAME_W-1:0] limit,
  input  logic [2:0]         speed,
  input  logic [1:0]         mode,
  input  logic               run,
  input  logic               step,
  output logic [ANI_W-1:0]   ani_q,
  output logic [FRAME_W-1:0] frame,
  output logic               frame_tick,
  output logic               wrap,
  output logic               done,
  output logic               ani_changed
);
  state_t             state;
  logic               dir_down, step_d;
  logic [1:0]         mode_d;
  logic               tick_q, wrap_q, chg_q;
  logic               chg, presc_tick, adv, term;
  logic [FRAME_W-1:0] nxt_frame;
  logic               nxt_down, nxt_tick, nxt_wrap;

  assign chg = (animation != ani_q);

  anim_prescaler #(.BASE_DIV(BASE_DIV), .PRESC_W(PRESC_W)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ena && state == ST_RUN),
    .clr   (ena && chg),
    .speed (speed),
    .tick  (presc_tick)
  );

  assign adv = !chg && ((state == ST_RUN && presc_tick) ||
                        (state == ST_HOLD && step && !step_d));

  always_comb begin
    nxt_frame = frame;
    nxt_down  = dir_down;
    nxt_tick  = 1'b0;
    nxt_wrap  = 1'b0;
    term      = 1'b0;
    if (adv) begin
      nxt_tick = 1'b1;
      if (mode == MODE_ONESHOT) begin
        if (frame < limit) nxt_frame = frame + 6'd1;
        else begin
          nxt_wrap = 1'b1;
          nxt_tick = 1'b0;
          term     = 1'b1;
        end
      end else if (frame > limit) begin
        // limit shrank under us: restart the sequence
        nxt_frame = '0;
        nxt_down  = 1'b0;
        nxt_wrap  = 1'b1;
      end else if (mode == MODE_PINGPONG) begin
        if (!dir_down) begin
          if (frame < limit) nxt_frame = frame + 6'd1;
          else begin
            nxt_down  = 1'b1;
            nxt_frame = (limit == '0) ? '0 : limit - 6'd1;
            nxt_wrap  = 1'b1;
          end
        end else begin
          if (frame != '0) nxt_frame = frame - 6'd1;
          else begin
            nxt_down  = 1'b0;
            nxt_frame = (limit == '0) ? '0 : 6'd1;
            nxt_wrap  = 1'b1;
          end
        end
      end else begin
        if (frame < limit) nxt_frame = frame + 6'd1;
        else begin
          nxt_frame = '0;
          nxt_wrap  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ani_q    <= '0;
      frame    <= '0;
      dir_down <= 1'b0;
      step_d   <= 1'b0;
      mode_d   <= '0;
      tick_q   <= 1'b0;
      wrap_q   <= 1'b0;
      chg_q    <= 1'b0;
      state    <= ST_HOLD;
    end else if (!ena) begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      step_d <= step;
      mode_d <= mode;
      chg_q  <= 1'b0;
      if (chg) begin
        ani_q    <= animation;
        frame    <= '0;
        dir_down <= 1'b0;
        tick_q   <= 1'b0;
        wrap_q   <= 1'b0;
        chg_q    <= 1'b1;
        state    <= run ? ST_RUN : ST_HOLD;
      end else begin
        frame    <= nxt_frame;
        dir_down <= nxt_down;
        tick_q   <= nxt_tick;
        wrap_q   <= nxt_wrap;
        case (state)
          ST_RUN:  if (term) state <= ST_DONE;
                   else if (!run) state <= ST_HOLD;
          ST_HOLD: if (run) state <= ST_RUN;
          ST_DONE: if (mode != mode_d) state <= run ? ST_RUN : ST_HOLD;
          default: state <= ST_HOLD;
        endcase
      end
    end
  end

  assign frame_tick  = tick_q & ena;
  assign wrap        = wrap_q & ena;
  assign ani_changed = chg_q & ena;
  assign done        = (state == ST_DONE);
endmodule

// File: tb/tb_anim_sequencer.sv
// Bench for anim_sequencer: per-cycle reference model plus directed scenarios.
module tb_anim_sequencer;
  localparam int BD = 8;
  localparam int PLAY = 0, PAUSE = 1, FIN = 2;

  logic       clk = 1'b0, rst_n = 1'b0, ena = 1'b1, run = 1'b0, step = 1'b0;
  logic [5:0] animation = '0, limit, ani_q, frame;
  logic [2:0] speed = '0;
  logic [1:0] mode = '0;
  logic       frame_tick, wrap, done, ani_changed;

  int checks = 0, failures = 0;

  anim_sequencer #(.BASE_DIV(BD), .PRESC_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .animation(animation), .limit(limit),
    .speed(speed), .mode(mode), .run(run), .step(step), .ani_q(ani_q),
    .frame(frame), .frame_tick(frame_tick), .wrap(wrap), .done(done),
    .ani_changed(ani_changed)
  );

  always #5 clk = ~clk;

  function automatic int lut(int a);
    case (a)
      0: return 9;
      1: return 11;
      7: return 1;
      8: return 3;
      default: return 63;
    endcase
  endfunction

  assign limit = 6'(lut(int'(ani_q)));

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference model: playback rules stated directly on integers
  int m_ani, m_frame, m_cnt, m_st, m_moded, lim, per, st0;
  bit m_down, m_stepd, m_tick, m_wrap, m_chg, m_valid, adv, fin;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_ani = 0; m_frame = 0; m_cnt = 0; m_st = PAUSE; m_moded = 0;
      m_down = 0; m_stepd = 0; m_tick = 0; m_wrap = 0; m_chg = 0;
      m_valid = 1;
    end else if (!ena) begin
      m_tick = 0; m_wrap = 0; m_chg = 0;
    end else begin
      m_tick = 0; m_wrap = 0; m_chg = 0;
      if (int'(animation) != m_ani) begin
        m_ani = int'(animation); m_frame = 0; m_down = 0; m_cnt = 0; m_chg = 1;
        m_st = run ? PLAY : PAUSE;
      end else begin
        adv = 0; fin = 0; st0 = m_st;
        per = BD >> speed;
        if (per < 1) per = 1;
        if (st0 == PLAY) begin
          if (m_cnt >= per - 1) begin m_cnt = 0; adv = 1; end
          else m_cnt++;
        end else if (st0 == PAUSE && step && !m_stepd) adv = 1;
        if (adv) begin
          lim = lut(m_ani);
          if (mode == 2'b01) begin
            if (m_frame < lim) begin m_frame++; m_tick = 1; end
            else begin m_wrap = 1; fin = 1; end
          end else if (m_frame > lim) begin
            m_frame = 0; m_wrap = 1; m_down = 0; m_tick = 1;
          end else if (mode == 2'b10) begin
            m_tick = 1;
            if (!m_down) begin
              if (m_frame < lim) m_frame++;
              else begin m_down = 1; m_frame = (lim > 0) ? lim - 1 : 0; m_wrap = 1; end
            end else begin
              if (m_frame > 0) m_frame--;
              else begin m_down = 0; m_frame = (lim > 0) ? 1 : 0; m_wrap = 1; end
            end
          end else begin
            m_tick = 1;
            if (m_frame < lim) m_frame++;
            else begin m_frame = 0; m_wrap = 1; end
          end
        end
        if (st0 == PLAY) m_st = fin ? FIN : (run ? PLAY : PAUSE);
        else if (st0 == PAUSE) m_st = run ? PLAY : PAUSE;
        else if (int'(mode) != m_moded) m_st = run ? PLAY : PAUSE;
      end
      m_stepd = step;
      m_moded = int'(mode);
    end
  end

  always @(negedge clk) begin
    #2;
    if (m_valid) begin
      chk("model_ani_q", ani_q, m_ani);
      chk("model_frame", frame, m_frame);
      chk("model_frame_tick", frame_tick, m_tick & ena);
      chk("model_wrap", wrap, m_wrap & ena);
      chk("model_done", done, m_st == FIN);
      chk("model_ani_changed", ani_changed, m_chg & ena);
    end
  end

  task automatic wait_tick(output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!frame_tick && c < 200);
    if (!frame_tick) chk("tick_timeout", 0, 1);
  endtask

  int c, nt, f0;
  int pp_f[7] = '{1, 2, 3, 2, 1, 0, 1};
  int pp_w[7] = '{0, 0, 0, 1, 0, 0, 1};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ani_q", ani_q, 0);
    chk("rst_frame", frame, 0);
    chk("rst_done", done, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_chg", ani_changed, 0);
    rst_n = 1; run = 1; mode = 2'b00; speed = 0; animation = 0;

    wait_tick(c);
    chk("loop_first", frame, 1);
    for (int i = 2; i <= 10; i++) begin
      wait_tick(c);
      chk("loop_period", c, 8);
      chk("loop_frame", frame, i % 10);
      chk("loop_wrap", wrap, i == 10);
    end

    repeat (5) wait_tick(c);
    chk("mid_frame5", frame, 5);
    animation = 1;
    @(negedge clk);
    chk("chg_ani_q", ani_q, 1);
    chk("chg_frame", frame, 0);
    chk("chg_pulse", ani_changed, 1);
    wait_tick(c);
    chk("chg_restart", c, 8);
    chk("chg_frame1", frame, 1);
    for (int i = 2; i <= 12; i++) begin
      wait_tick(c);
      chk("l11_frame", frame, i % 12);
      chk("l11_wrap", wrap, i == 12);
    end

    mode = 2'b01; animation = 7;
    @(negedge clk);
    chk("os_chg", ani_changed, 1);
    chk("os_frame0", frame, 0);
    wait_tick(c);
    chk("os_frame1", frame, 1);
    chk("os_nowrap", wrap, 0);
    c = 0;
    do begin @(negedge clk); c++; end while (!done && c < 40);
    chk("os_done", done, 1);
    chk("os_wrap", wrap, 1);
    chk("os_hold", frame, 1);
    chk("os_notick", frame_tick, 0);
    repeat (2) begin
      step = 1; repeat (3) @(negedge clk);
      step = 0; repeat (3) @(negedge clk);
    end
    chk("os_step_frame", frame, 1);
    chk("os_step_done", done, 1);

    mode = 2'b10; animation = 8;
    @(negedge clk);
    chk("pp_done_clr", done, 0);
    chk("pp_frame0", frame, 0);
    for (int i = 0; i < 7; i++) begin
      wait_tick(c);
      chk("pp_frame", frame, pp_f[i]);
      chk("pp_wrap", wrap, pp_w[i]);
    end

    mode = 2'b00; animation = 0;
    @(negedge clk);
    repeat (4) wait_tick(c);
    chk("pause_at4", frame, 4);
    run = 0;
    nt = 0;
    repeat (100) begin @(negedge clk); nt += int'(frame_tick); end
    chk("pause_ticks", nt, 0);
    chk("pause_frame", frame, 4);
    for (int s = 0; s < 3; s++) begin
      nt = 0;
      step = 1; repeat (4) begin @(negedge clk); nt += int'(frame_tick); end
      step = 0; repeat (4) begin @(negedge clk); nt += int'(frame_tick); end
      chk("step_ticks", nt, 1);
      chk("step_frame", frame, 5 + s);
    end
    run = 1;
    wait_tick(c);
    chk("resume_cnt", c, 8);
    chk("resume_frame", frame, 8);

    speed = 7;
    for (int i = 0; i < 3; i++) begin
      wait_tick(c);
      chk("fast_period", c, 1);
    end
    speed = 0;
    repeat (5) @(negedge clk);
    speed = 2;
    @(negedge clk);
    chk("speedup_tick", frame_tick, 1);
    chk("speedup_frame", frame, 2);

    animation = 2; speed = 7;
    @(negedge clk);
    repeat (63) @(negedge clk);
    chk("l63_top", frame, 63);
    @(negedge clk);
    chk("l63_wrap_frame", frame, 0);
    chk("l63_wrap", wrap, 1);

    f0 = int'(frame);
    ena = 0; animation = 3;
    nt = 0;
    repeat (20) begin @(negedge clk); nt += int'(frame_tick | wrap | ani_changed); end
    chk("ena_pulses", nt, 0);
    chk("ena_frame", frame, f0);
    chk("ena_ani_q", ani_q, 2);
    ena = 1;
    @(negedge clk);
    chk("ena_resume_chg", ani_changed, 1);
    chk("ena_resume_ani", ani_q, 3);
    repeat (5) @(negedge clk);

    rst_n = 0;
    @(negedge clk);
    chk("rst2_ani_q", ani_q, 0);
    chk("rst2_frame", frame, 0);
    chk("rst2_done", done, 0);
    chk("rst2_tick", frame_tick, 0);
    chk("rst2_chg", ani_changed, 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
